converge_delta_unit: RTL and testbench

CONVERGE_DELTA_UNIT -- requirements
Module: converge_delta_unit

---
 rtl/converge_delta_unit.sv | 202 ++++++++++++++++++++
 tb/tb_converge_delta_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/converge_delta_unit.sv
// Output-layer delta unit: per-neuron delta = sat((act - target) * adot) with a running argmax/accuracy tracker.
// Optional macro ACC_COUNT_EN enables the saturating correct_count accumulator.
module converge_delta_unit #(
    parameter int unsigned z        = 8,
    parameter int unsigned fi       = 4,
    parameter int unsigned width    = 16,
    parameter int unsigned int_bits = 5,
    parameter int unsigned n_out    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [width*(z/fi)-1:0]  act_in_package,
    input  logic [width*(z/fi)-1:0]  adot_in_package,
    input  logic [z/fi-1:0]          ideal_in,
    input  logic                     count_clr,
    output logic [width*(z/fi)-1:0]  del_out_package,
    output logic                     del_valid,
    output logic                     sample_done,
    output logic [$clog2(n_out)-1:0] pred_idx,
    output logic                     correct,
    output logic [15:0]              correct_count
);

    localparam int unsigned LANES  = z / fi;
    localparam int unsigned FRAC   = width - int_bits - 1;
    localparam int unsigned NCHUNK = n_out / LANES;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned IW     = $clog2(n_out);
    localparam int unsigned DW     = width + 2;
    localparam int unsigned PW     = 2 * width;

    localparam logic signed [DW-1:0] ONE     = DW'(2 ** FRAC);
    localparam logic signed [DW-1:0] ZERO    = '0;
    localparam logic signed [DW-1:0] DIFF_HI = DW'(2 ** (width - 1) - 1);
    localparam logic signed [DW-1:0] DIFF_LO = ~DIFF_HI;
    localparam logic signed [PW-1:0] DEL_HI  = PW'(2 ** (width - 1) - 1);
    localparam logic signed [PW-1:0] DEL_LO  = ~DEL_HI;

    logic [CW-1:0]           chunk_q, chunk_d;
    logic [width-1:0]        max_q, max_d, scan_max_c;
    logic [IW-1:0]           max_idx_q, max_idx_d, scan_idx_c;
    logic                    tgt_found_q, tgt_found_d, scan_found_c;
    logic [IW-1:0]           tgt_idx_q, tgt_idx_d, scan_tgt_c;
    logic                    last_c, correct_c;
    logic [IW-1:0]           nidx_c  [LANES];
    logic signed [DW-1:0]    dfull_c [LANES];
    logic signed [width-1:0] diff_c  [LANES];

    logic                    s1_valid_q, s1_last_q, s1_correct_q;
    logic [IW-1:0]           s1_pred_q;
    logic signed [width-1:0] s1_diff_q [LANES];
    logic [width-1:0]        s1_adot_q [LANES];

    logic signed [PW-1:0]    prod_c [LANES];
    logic signed [PW-1:0]    shr_c  [LANES];
    logic [width*LANES-1:0]  del_c;

    // Stage 0: chunk counter, trackers (seeded fresh on chunk 0) and saturated diff
    always_comb begin
        chunk_d      = chunk_q;
        max_d        = max_q;
        max_idx_d    = max_idx_q;
        tgt_found_d  = tgt_found_q;
        tgt_idx_d    = tgt_idx_q;
        nidx_c       = '{default: '0};
        dfull_c      = '{default: '0};
        diff_c       = '{default: '0};
        last_c       = (chunk_q == CW'(NCHUNK - 1));
        scan_max_c   = (chunk_q == '0) ? '0 : max_q;
        scan_idx_c   = (chunk_q == '0) ? '0 : max_idx_q;
        scan_found_c = (chunk_q == '0) ? 1'b0 : tgt_found_q;
        scan_tgt_c   = (chunk_q == '0) ? '0 : tgt_idx_q;
        for (int k = 0; k < int'(LANES); k++) begin
            nidx_c[k] = IW'(int'(chunk_q) * int'(LANES) + k);
            if (act_in_package[k*width +: width] > scan_max_c) begin
                scan_max_c = act_in_package[k*width +: width];
                scan_idx_c = nidx_c[k];
            end
            if (!scan_found_c && ideal_in[k]) begin
                scan_found_c = 1'b1;
                scan_tgt_c   = nidx_c[k];
            end
            dfull_c[k] = $signed({2'b00, act_in_package[k*width +: width]}) - (ideal_in[k] ? ONE : ZERO);
            if (dfull_c[k] > DIFF_HI) begin
                diff_c[k] = DIFF_HI[width-1:0];
            end else if (dfull_c[k] < DIFF_LO) begin
                diff_c[k] = DIFF_LO[width-1:0];
            end else begin
                diff_c[k] = dfull_c[k][width-1:0];
            end
        end
        correct_c = scan_found_c && (scan_tgt_c == scan_idx_c);
        if (in_valid) begin
            chunk_d     = last_c ? '0 : chunk_q + CW'(1);
            max_d       = scan_max_c;
            max_idx_d   = scan_idx_c;
            tgt_found_d = scan_found_c;
            tgt_idx_d   = scan_tgt_c;
        end
    end

    // Stage 2 arithmetic: signed diff * signed adot, arithmetic shift, saturate
    always_comb begin
        prod_c = '{default: '0};
        shr_c  = '{default: '0};
        del_c  = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            prod_c[k] = $signed({{width{s1_diff_q[k][width-1]}}, s1_diff_q[k]})
                      * $signed({{width{s1_adot_q[k][width-1]}}, s1_adot_q[k]});
            shr_c[k]  = prod_c[k] >>> FRAC;
            if (shr_c[k] > DEL_HI) begin
                del_c[k*width +: width] = DEL_HI[width-1:0];
            end else if (shr_c[k] < DEL_LO) begin
                del_c[k*width +: width] = DEL_LO[width-1:0];
            end else begin
                del_c[k*width +: width] = shr_c[k][width-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chunk_q         <= '0;
            max_q           <= '0;
            max_idx_q       <= '0;
            tgt_found_q     <= 1'b0;
            tgt_idx_q       <= '0;
            s1_valid_q      <= 1'b0;
            s1_last_q       <= 1'b0;
            s1_pred_q       <= '0;
            s1_correct_q    <= 1'b0;
            for (int k = 0; k < int'(LANES); k++) begin
                s1_diff_q[k] <= '0;
                s1_adot_q[k] <= '0;
            end
            del_out_package <= '0;
            del_valid       <= 1'b0;
            sample_done     <= 1'b0;
            pred_idx        <= '0;
            correct         <= 1'b0;
        end else begin
            chunk_q     <= chunk_d;
            max_q       <= max_d;
            max_idx_q   <= max_idx_d;
            tgt_found_q <= tgt_found_d;
            tgt_idx_q   <= tgt_idx_d;
            s1_valid_q  <= in_valid;
            if (in_valid) begin
                s1_last_q    <= last_c;
                s1_pred_q    <= scan_idx_c;
                s1_correct_q <= correct_c;
                for (int k = 0; k < int'(LANES); k++) begin
                    s1_diff_q[k] <= diff_c[k];
                    s1_adot_q[k] <= adot_in_package[k*width +: width];
                end
            end
            del_valid   <= s1_valid_q;
            sample_done <= s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                del_out_package <= del_c;
            end
            if (s1_valid_q && s1_last_q) begin
                pred_idx <= s1_pred_q;
                correct  <= s1_correct_q;
            end
        end
    end

`ifdef ACC_COUNT_EN
    logic        inc_c;
    logic [15:0] count_d;

    // Increment lands on the same edge as sample_done; a coinciding clear restarts at 1
    always_comb begin
        inc_c   = s1_valid_q & s1_last_q & s1_correct_q;
        count_d = correct_count;
        if (inc_c) begin
            if (count_clr) begin
                count_d = 16'd1;
            end else if (correct_count != 16'hFFFF) begin
                count_d = correct_count + 16'd1;
            end
        end else if (count_clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            correct_count <= '0;
        end else begin
            correct_count <= count_d;
        end
    end
`else
    logic unused_count_clr;
    assign unused_count_clr = count_clr;
    assign correct_count    = '0;
`endif

endmodule

// File: tb/tb_converge_delta_unit.sv
// Bench for converge_delta_unit: directed corner samples then randomized samples against a reference model.
module tb_converge_delta_unit;

    localparam int W   = 16;
    localparam int L   = 2;
    localparam int NO  = 8;
    localparam int NCH = NO / L;
    localparam int FB  = 10;
    localparam int PKW = W * L;

    logic           clk = 1'b0;
    logic           reset, in_valid, count_clr;
    logic [PKW-1:0] act_pkg, adot_pkg, del_pkg;
    logic [L-1:0]   ideal;
    logic           del_valid, sample_done, correct;
    logic [2:0]     pred_idx;
    logic [15:0]    correct_count;

    always #5 clk = ~clk;

    converge_delta_unit #(.z(8), .fi(4), .width(16), .int_bits(5), .n_out(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .act_in_package  (act_pkg),
        .adot_in_package (adot_pkg),
        .ideal_in        (ideal),
        .count_clr       (count_clr),
        .del_out_package (del_pkg),
        .del_valid       (del_valid),
        .sample_done     (sample_done),
        .pred_idx        (pred_idx),
        .correct         (correct),
        .correct_count   (correct_count)
    );

    typedef struct {
        bit             v;
        bit             last;
        logic [PKW-1:0] del;
        int             pred;
        bit             corr;
    } exp_t;

    exp_t       pipe[$];
    int         checks = 0;
    int         failures = 0;
    int         chunk_idx, exp_pred, exp_cnt, sd_seen;
    bit         exp_corr;
    logic [W-1:0] s_act [NO];
    bit         s_ideal [NO];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Delta from plain integer arithmetic: floor((sat(act - target) * adot) / 2^FB), saturated
    function automatic logic [W-1:0] del_ref(input logic [W-1:0] a, input bit id, input logic [W-1:0] ad);
        longint diff, p, d;
        diff = longint'(a) - (id ? 64'sd1024 : 64'sd0);
        if (diff > 32767) diff = 32767;
        if (diff < -32768) diff = -32768;
        p = diff * longint'($signed(ad));
        d = p >>> FB;
        if (d > 32767) d = 32767;
        if (d < -32768) d = -32768;
        return d[W-1:0];
    endfunction

    task automatic cycle(input bit v, input logic [PKW-1:0] a, input logic [PKW-1:0] ad,
                         input logic [L-1:0] id, input bit clr);
        exp_t e, cur;
        int   mx, pi, tg;
        bit   sd;
        e.v = v; e.last = 1'b0; e.del = '0; e.pred = 0; e.corr = 1'b0;
        if (v) begin
            for (int k = 0; k < L; k++) begin
                s_act[chunk_idx*L+k]   = a[k*W +: W];
                s_ideal[chunk_idx*L+k] = id[k];
                e.del[k*W +: W]        = del_ref(a[k*W +: W], id[k], ad[k*W +: W]);
            end
            if (chunk_idx == NCH - 1) begin
                mx = -1; pi = 0; tg = -1;
                for (int n = 0; n < NO; n++) begin
                    if (int'(s_act[n]) > mx) begin
                        mx = int'(s_act[n]);
                        pi = n;
                    end
                    if (tg < 0 && s_ideal[n]) tg = n;
                end
                e.last = 1'b1; e.pred = pi; e.corr = (tg == pi);
                chunk_idx = 0;
            end else begin
                chunk_idx++;
            end
        end
        pipe.push_back(e);
        in_valid = v; act_pkg = a; adot_pkg = ad; ideal = id; count_clr = clr;
        @(posedge clk);
        #1;
        cur = pipe.pop_front();
        sd  = cur.v && cur.last;
        if (sd) begin
            exp_pred = cur.pred;
            exp_corr = cur.corr;
        end
`ifdef ACC_COUNT_EN
        if (sd && cur.corr) exp_cnt = clr ? 1 : ((exp_cnt == 65535) ? 65535 : exp_cnt + 1);
        else if (clr) exp_cnt = 0;
`endif
        if (sample_done === 1'b1) sd_seen++;
        check("del_valid", 32'(del_valid), 32'(cur.v));
        if (cur.v) check("del_out", del_pkg, cur.del);
        check("sample_done", 32'(sample_done), 32'(sd));
        check("pred_idx", 32'(pred_idx), 32'(exp_pred));
        check("correct", 32'(correct), 32'(exp_corr));
        check("correct_count", 32'(correct_count), 32'(exp_cnt));
    endtask

    task automatic idle(input bit clr);
        cycle(1'b0, PKW'($urandom), PKW'($urandom), L'($urandom), clr);
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        reset = 1'b1; in_valid = 1'b1; count_clr = 1'b1;
        act_pkg = PKW'($urandom); adot_pkg = PKW'($urandom); ideal = '1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0; count_clr = 1'b0;
        pipe.delete();
        e.v = 1'b0; e.last = 1'b0; e.del = '0; e.pred = 0; e.corr = 1'b0;
        pipe.push_back(e);
        chunk_idx = 0; exp_pred = 0; exp_corr = 1'b0; exp_cnt = 0;
        check("rst_del_valid", 32'(del_valid), 32'd0);
        check("rst_del_out", del_pkg, 32'd0);
        check("rst_sample_done", 32'(sample_done), 32'd0);
        check("rst_pred_idx", 32'(pred_idx), 32'd0);
        check("rst_correct", 32'(correct), 32'd0);
        check("rst_count", 32'(correct_count), 32'd0);
    endtask

    task automatic send_sample(input logic [W-1:0] acts [NO], input logic [NO-1:0] ids, input bit rnd);
        logic [PKW-1:0] a;
        for (int c = 0; c < NCH; c++) begin
            if (rnd && $urandom_range(3) == 0) idle($urandom_range(15) == 0);
            for (int k = 0; k < L; k++) a[k*W +: W] = acts[c*L+k];
            cycle(1'b1, a, PKW'($urandom), ids[c*L +: L], rnd && ($urandom_range(15) == 0));
        end
    endtask

    logic [W-1:0] acts [NO];
    logic [NO-1:0] ids;
    int           sd0, t, r;

    initial begin
        reset = 1'b0; in_valid = 1'b0; count_clr = 1'b0;
        act_pkg = '0; adot_pkg = '0; ideal = '0;
        do_reset(2);

        // Basic deltas on chunk 0, saturation corners on chunk 1
        cycle(1'b1, {16'h0200, 16'h0300}, {16'h0100, 16'h00C0}, 2'b01, 1'b0);
        idle(1'b0);
        check("basic_del", del_pkg, 32'h0080_FFD0);
        cycle(1'b1, {16'hFFFF, 16'hFFFF}, {16'h8000, 16'h7FFF}, 2'b00, 1'b0);
        idle(1'b0);
        check("sat_del", del_pkg, 32'h8000_7FFF);
        cycle(1'b1, 32'h0, PKW'($urandom), 2'b00, 1'b0);
        cycle(1'b1, 32'h0, PKW'($urandom), 2'b00, 1'b0);
        idle(1'b0);
        check("s1_done", 32'(sample_done), 32'd1);
        check("s1_pred", 32'(pred_idx), 32'd2);
        idle(1'b0);

        // Neuron 5 maximal and target
        for (int n = 0; n < NO; n++) acts[n] = 16'h0100;
        acts[5] = 16'h6000;
        send_sample(acts, 8'b0010_0000, 1'b0);
        idle(1'b0);
        check("n5_done", 32'(sample_done), 32'd1);
        check("n5_pred", 32'(pred_idx), 32'd5);
        check("n5_correct", 32'(correct), 32'd1);
`ifdef ACC_COUNT_EN
        check("n5_count", 32'(correct_count), 32'd1);
`endif

        // Tie between neurons 2 and 6, target 6; back-to-back with the previous tail
        for (int n = 0; n < NO; n++) acts[n] = 16'h0050;
        acts[2] = 16'h4000;
        acts[6] = 16'h4000;
        send_sample(acts, 8'b0100_0000, 1'b0);
        idle(1'b0);
        check("tie_pred", 32'(pred_idx), 32'd2);
        check("tie_correct", 32'(correct), 32'd0);

        // Partial sample abandoned by reset
        sd0 = sd_seen;
        cycle(1'b1, PKW'($urandom), PKW'($urandom), 2'b11, 1'b0);
        cycle(1'b1, PKW'($urandom), PKW'($urandom), 2'b11, 1'b0);
        do_reset(1);
        for (int n = 0; n < NO; n++) acts[n] = 16'(n * 16);
        send_sample(acts, 8'b1000_0000, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("rst_single_done", 32'(sd_seen - sd0), 32'd1);
        check("rst_pred", 32'(pred_idx), 32'd7);
        check("rst_correct", 32'(correct), 32'd1);

        // Another correct sample, then a clear coinciding with a correct sample_done
        acts[7] = 16'h0000;
        acts[3] = 16'h7FFF;
        send_sample(acts, 8'b0000_1000, 1'b0);
        idle(1'b0);
        send_sample(acts, 8'b0000_1000, 1'b0);
        idle(1'b1);
        check("clr_done", 32'(sample_done), 32'd1);
`ifdef ACC_COUNT_EN
        check("clr_coincide", 32'(correct_count), 32'd1);
`else
        check("clr_disabled", 32'(correct_count), 32'd0);
`endif
        idle(1'b1);

        // Randomized samples with gaps, ties, empty and multi-bit targets
        for (int s = 0; s < 25; s++) begin
            r = $urandom_range(3);
            t = $urandom_range(NO - 1);
            for (int n = 0; n < NO; n++) acts[n] = (s % 4 == 1) ? W'($urandom_range(3)) : W'($urandom);
            case (r)
                0:       ids = '0;
                1:       ids = NO'($urandom);
                default: ids = NO'(1) << t;
            endcase
            if (r == 3) acts[t] = 16'hFFFF;
            send_sample(acts, ids, 1'b1);
        end
        idle(1'b0);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
